scan_shift_chain: RTL

Serial scan-chain stage that sits directly upstream of the reset latch in each generated scan segment. It shifts a configuration word in bit by bit and counts the bits received. On a validated update request it drives a timed transparency pulse that copies the word into the downstream latch. It also passes the shifted-out bits to the next segment through `io_scan_out`.

---
 rtl/scan_shift_chain_pkg.sv | 13 +
 rtl/scan_shift_chain_if.sv | 24 ++
 rtl/scan_shift_chain_timer.sv | 28 ++
 rtl/scan_shift_chain.sv | 78 +++++++
 4 files changed

// File: rtl/scan_shift_chain_pkg.sv
// Shared types and helpers for the scan shift chain segment.
package scan_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} scan_state_t;

  localparam int SCAN_UPDATE_CYCLES = 2;

  // Width needed to hold a bit count in the range 0..w.
  function automatic int count_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/scan_shift_chain_if.sv
// Scan control and data bundle between a segment driver and the chain stage.
interface scan_shift_chain_if #(parameter int WIDTH = 8);
  localparam int CW = scan_pkg::count_w(WIDTH);

  logic          io_scan_en;
  logic          io_scan_in;
  logic          io_scan_update;
  logic          io_scan_out;
  logic [WIDTH-1:0] io_data;
  logic          io_latch_en;
  logic          io_busy;
  logic [CW-1:0] io_count;
  logic          io_err;

  modport master (
    output io_scan_en, io_scan_in, io_scan_update,
    input  io_scan_out, io_data, io_latch_en, io_busy, io_count, io_err
  );

  modport slave (
    input  io_scan_en, io_scan_in, io_scan_update,
    output io_scan_out, io_data, io_latch_en, io_busy, io_count, io_err
  );
endinterface

// File: rtl/scan_shift_chain_timer.sv
// Loadable down-counter that times the latch transparency pulse.
module scan_update_timer
  import scan_pkg::*;
#(
  parameter int UPDATE_CYCLES = SCAN_UPDATE_CYCLES,
  parameter int TW            = count_w(UPDATE_CYCLES)
) (
  input  logic          io_clk,
  input  logic          io_rst_n,
  input  logic [TW-1:0] load,
  input  logic          start,
  output logic          active,
  output logic          done
);

  logic [TW-1:0] cnt;

  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n)        cnt <= '0;
    else if (start)       cnt <= load;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign active = (cnt != '0);
  // done marks the last active cycle so the FSM leaves UPDATE on the same edge
  assign done   = (cnt == TW'(1));

endmodule

// File: rtl/scan_shift_chain.sv
// Scan chain stage: serial shift-in with bit count, validated update pulse to the latch.
module scan_shift_chain
  import scan_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int UPDATE_CYCLES = SCAN_UPDATE_CYCLES
) (
  input  logic              io_clk,
  input  logic              io_rst_n,
  scan_shift_chain_if.slave bus
);

  localparam int CW = count_w(WIDTH);
  localparam int TW = count_w(UPDATE_CYCLES);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  scan_state_t      state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    count;
  logic             err;
  logic             start, t_active, t_done;

  // An update is accepted only with a complete frame and no concurrent shift.
  assign start = (state != UPDATE) && !bus.io_scan_en && bus.io_scan_update && (count == FULL);

  scan_update_timer #(.UPDATE_CYCLES(UPDATE_CYCLES), .TW(TW)) u_timer (
    .io_clk   (io_clk),
    .io_rst_n (io_rst_n),
    .load     (TW'(UPDATE_CYCLES)),
    .start    (start),
    .active   (t_active),
    .done     (t_done)
  );

  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      state <= IDLE;
      sr    <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE, SHIFT: begin
          if (bus.io_scan_en) begin
            sr    <= {sr[WIDTH-2:0], bus.io_scan_in};
            state <= SHIFT;
            if (count != FULL) count <= count + 1'b1;
            if (bus.io_scan_update) err <= 1'b1;
          end else if (bus.io_scan_update) begin
            if (count == FULL) begin
              state <= UPDATE;
              err   <= 1'b0;
            end else begin
              state <= IDLE;
              count <= '0;
              err   <= 1'b1;
            end
          end
        end
        UPDATE: begin
          if (t_done) begin
            state <= IDLE;
            count <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.io_scan_out = sr[WIDTH-1];
  assign bus.io_data     = sr;
  assign bus.io_latch_en = t_active;
  assign bus.io_busy     = (state == UPDATE);
  assign bus.io_count    = count;
  assign bus.io_err      = err;

endmodule
